// File: rtl/mpmc11_app_cmd_seq.sv
// Burst command sequencer for the MIG app port with read-return credit flow control.
// Defining MPMC11_CMD_SEQ_PERF_EN adds the perf_cmds / perf_stall counters.
module mpmc11_app_cmd_seq #(
  parameter int ADDR_WIDTH = 29,
  parameter int CNT_WIDTH  = 6,
  parameter int ADDR_STEP  = 8,
  parameter int RD_CREDITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [CNT_WIDTH-1:0]  req_cnt,
  output logic [2:0]            app_cmd,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic                  app_en,
  input  logic                  app_rdy,
  input  logic                  rd_data_valid,
  output logic                  busy,
  output logic                  done
`ifdef MPMC11_CMD_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_cmds,
  output logic [31:0]           perf_stall
`endif
);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam int CRW = $clog2(RD_CREDITS + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ISSUE, STALL} state_t;

  state_t               state;
  state_t               state_next;
  logic                 wr_q;
  logic [CNT_WIDTH-1:0] remaining;
  logic [CRW-1:0]       credits;
  logic [CRW-1:0]       credits_next;
  logic                 accept;
  logic                 rd_accept;
  logic                 last_cmd;

  assign accept    = (state == ISSUE) && app_rdy;
  assign rd_accept = accept && !wr_q;
  assign last_cmd  = (remaining == CNT_WIDTH'(1));

  // A read accept and a returned beat in the same cycle cancel out; returns saturate.
  always_comb begin
    credits_next = credits;
    if (rd_accept && !rd_data_valid)
      credits_next = credits - CRW'(1);
    else if (!rd_accept && rd_data_valid && (credits != CRW'(RD_CREDITS)))
      credits_next = credits + CRW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (req_valid) state_next = SETUP;
      SETUP: state_next = (!wr_q && (credits == '0)) ? STALL : ISSUE;
      ISSUE: begin
        if (accept) begin
          if (last_cmd)
            state_next = IDLE;
          else if (!wr_q && (credits_next == '0))
            state_next = STALL;
        end
      end
      STALL: if (credits != '0) state_next = ISSUE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    app_en    = (state == ISSUE);
    busy      = (state != IDLE);
    req_ready = (state == IDLE);
  end

  // The command only changes on edges leaving a cycle with app_en low, or on the final accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q      <= 1'b0;
      remaining <= '0;
      app_addr  <= '0;
      app_cmd   <= CMD_WRITE;
      credits   <= CRW'(RD_CREDITS);
      done      <= 1'b0;
    end else begin
      credits <= credits_next;
      done    <= accept && last_cmd;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q      <= req_wr;
            app_addr  <= req_addr;
            remaining <= (req_cnt == '0) ? CNT_WIDTH'(1) : req_cnt;
          end
        end
        SETUP: app_cmd <= wr_q ? CMD_WRITE : CMD_READ;
        ISSUE: begin
          if (accept) begin
            app_addr  <= app_addr + ADDR_WIDTH'(ADDR_STEP);
            remaining <= remaining - CNT_WIDTH'(1);
            if (last_cmd) app_cmd <= CMD_WRITE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MPMC11_CMD_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cmds  <= '0;
      perf_stall <= '0;
    end else begin
      if (accept)
        perf_cmds <= perf_cmds + 32'd1;
      if ((state == STALL) || ((state == ISSUE) && !app_rdy))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mpmc11_app_cmd_seq.sv
// Scoreboard bench for mpmc11_app_cmd_seq: the stimulus pushes expected commands, a monitor pops them.
// Also exercises the perf counters when MPMC11_CMD_SEQ_PERF_EN is defined.
module tb_mpmc11_app_cmd_seq;
  localparam int AW   = 29;
  localparam int CW   = 6;
  localparam int STEP = 8;
  localparam int CRED = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [CW-1:0] req_cnt = '0;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_en;
  logic          app_rdy = 1'b0;
  logic          rd_data_valid = 1'b0;
  logic          busy;
  logic          done;
`ifdef MPMC11_CMD_SEQ_PERF_EN
  logic [31:0]   perf_cmds;
  logic [31:0]   perf_stall;
`endif

  mpmc11_app_cmd_seq #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .ADDR_STEP(STEP), .RD_CREDITS(CRED)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_cnt(req_cnt), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_en(app_en), .app_rdy(app_rdy), .rd_data_valid(rd_data_valid), .busy(busy), .done(done)
`ifdef MPMC11_CMD_SEQ_PERF_EN
    , .perf_cmds(perf_cmds), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   credits_model = CRED;
  int   accepts = 0;
  int   hold_cycles = 0;
  bit   rd_en = 1'b1;
  bit   rd_excess = 1'b0;
  int   pulse_req = 0;
  bit   rdy_always = 1'b0;
  logic [7:0] pat_bits = '0;
  int   pat_len = 0;
  int   pat_gen = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives app_rdy (pattern, always-on or random) and read-data returns.
  initial begin
    int seen = 0;
    int idx = 0;
    int pulse_done = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pat_gen != seen) begin
        seen = pat_gen;
        idx = 0;
      end
      if (idx < pat_len) begin
        app_rdy = pat_bits[idx];
        idx++;
      end else if (rdy_always) app_rdy = 1'b1;
      else app_rdy = ($urandom_range(0, 3) != 0);
      if (pulse_req != pulse_done) begin
        rd_data_valid = 1'b1;
        pulse_done++;
      end else begin
        rd_data_valid = rd_excess || (rd_en && (credits_model < CRED) && ($urandom_range(0, 1) == 1));
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted command and checks protocol rules.
  initial begin
    exp_t          e;
    logic [2:0]    prev_cmd = 3'b000;
    logic [AW-1:0] prev_addr = '0;
    bit            prev_hold = 0;
    bit            expect_done = 0;
    bit            was_reset = 0;
    bit            lat_wr = 0;
    bit            lat_skip = 0;
    bit            rd_acc;
    int            lat_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("reset_app_en", app_en, 0);
        checkOutput("reset_app_cmd", app_cmd, 3'b000);
        checkOutput("reset_app_addr", app_addr, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        exp_q.delete();
        credits_model = CRED;
        accepts = 0;
        expect_done = 0;
        prev_hold = 0;
        lat_cnt = 0;
        prev_cmd = 3'b000;
        was_reset = 1;
      end else begin
        if (was_reset) begin
          checkOutput("ready_after_reset", req_ready, 1);
          was_reset = 0;
        end
        checkOutput("done_pulse", done, expect_done);
        expect_done = 0;
        if (done) begin
          checkOutput("idle_after_done", {busy, req_ready}, 2'b01);
`ifdef MPMC11_CMD_SEQ_PERF_EN
          checkOutput("perf_cmds", perf_cmds, accepts);
          checkOutput("perf_stall_min", (perf_stall >= hold_cycles), 1);
`endif
        end
        checkOutput("busy_vs_ready", busy, !req_ready);
        if (prev_hold) begin
          checkOutput("hold_en", app_en, 1);
          checkOutput("hold_cmd", app_cmd, prev_cmd);
          checkOutput("hold_addr", app_addr, prev_addr);
        end
        if ((app_cmd != prev_cmd) && (app_cmd == 3'b000))
          checkOutput("cmd_return_en_low", app_en, 0);
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 1) begin
            checkOutput("setup_en_low", app_en, 0);
            lat_skip = !lat_wr && (credits_model == 0);
          end else if (!lat_skip) begin
            checkOutput("first_cmd_latency", app_en, 1);
          end
        end
        if (req_valid && req_ready) begin
          lat_cnt = 2;
          lat_wr = req_wr;
        end
        if (app_en && (app_cmd == 3'b001))
          checkOutput("read_needs_credit", (credits_model > 0), 1);
        if (app_en && !app_rdy) hold_cycles++;
        rd_acc = 0;
        if (app_en && app_rdy) begin
          accepts++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_cmd", app_addr, 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            checkOutput("cmd", app_cmd, e.cmd);
            checkOutput("addr", app_addr, e.addr);
            if (e.last) expect_done = 1;
            rd_acc = (e.cmd == 3'b001);
          end
        end
        if (rd_acc && !rd_data_valid) credits_model--;
        else if (!rd_acc && rd_data_valid && (credits_model < CRED)) credits_model++;
        prev_hold = app_en && !app_rdy;
        prev_cmd = app_cmd;
        prev_addr = app_addr;
      end
    end
  end

  task automatic waitIdle(input int bound, input string name);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy && (exp_q.size() == 0) && !done) begin
        ok = 1;
        break;
      end
    end
    checkOutput(name, ok, 1);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues one request, pushes its expected commands at the handshake, optionally waits for completion.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input int cnt, input bit wait_idle);
    exp_t e;
    int n;
    bit hs = 0;
    longint a;
    n = (cnt == 0) ? 1 : cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_wr = wr;
    req_addr = addr;
    req_cnt = CW'(cnt);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        hs = 1;
        break;
      end
    end
    checkOutput("handshake_timeout", hs, 1);
    if (hs) begin
      for (int i = 0; i < n; i++) begin
        a = (longint'(addr) + longint'(i) * STEP) % (longint'(1) << AW);
        e.cmd = wr ? 3'b000 : 3'b001;
        e.addr = AW'(a);
        e.last = (i == n - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (wait_idle) waitIdle(2000, "burst_timeout");
  endtask

  initial begin
    int base;
    bit full;
    waitCycles(3);
    rst = 1'b1;

    $display("[TB] write burst 0x100 x4, app_rdy high");
    rdy_always = 1'b1;
    applyStimulus(1'b1, AW'(29'h100), 4, 1'b1);

    $display("[TB] read burst x3 with backpressure");
    pat_bits = 8'b1100_1000;
    pat_len = 8;
    pat_gen++;
    applyStimulus(1'b0, AW'(29'h2000), 3, 1'b1);
    pat_len = 0;

    $display("[TB] address wrap");
    applyStimulus(1'b1, AW'(29'h1FFFFFF8), 2, 1'b1);
    applyStimulus(1'b0, AW'(29'h1FFFFFF8), 2, 1'b1);

    $display("[TB] cnt = 0 issues one command");
    applyStimulus(1'b1, AW'(29'h40), 0, 1'b1);
    applyStimulus(1'b0, AW'(29'h80), 0, 1'b1);

    $display("[TB] credit stall with excess returns first");
    full = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (credits_model == CRED) begin
        full = 1;
        break;
      end
    end
    checkOutput("credit_refill_timeout", full, 1);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    rd_excess = 1'b1;
    waitCycles(3);
    rd_excess = 1'b0;
    base = accepts;
    applyStimulus(1'b0, AW'(29'h3000), 5, 1'b0);
    waitCycles(15);
    checkOutput("stall_after_credits", accepts - base, 2);
    checkOutput("stall_en_low", app_en, 0);
    pulse_req++;
    waitCycles(12);
    checkOutput("one_more_after_return", accepts - base, 3);
    rd_en = 1'b1;
    waitIdle(500, "credit_burst_timeout");

    $display("[TB] reset mid-burst");
    applyStimulus(1'b0, AW'(29'h500), 20, 1'b0);
    waitCycles(4);
    rst = 1'b0;
    waitCycles(2);
    rst = 1'b1;
    waitCycles(2);
    checkOutput("idle_after_reset", {busy, req_ready}, 2'b01);
    applyStimulus(1'b1, AW'(29'h600), 3, 1'b1);

    $display("[TB] randomized bursts");
    rdy_always = 1'b0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom()), int'($urandom_range(0, 10)), 1'b1);
    end

    waitCycles(5);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
